// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave register-file target.
package spi_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ADDR       = 3'd1,
        WDATA      = 3'd2,
        RDATA      = 3'd3,
        WAIT_DESEL = 3'd4
    } spi_state_e;

    // True when an address selects an implemented register-file entry.
    function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/spi_slave_regfile_if.sv
// Serial frame bus between an SPI master (bench driver) and the register-file slave.
interface spi_slave_regfile_if;

    logic ssel;
    logic rd_wr;
    logic mosi;
    logic miso;
    logic frame_done;
    logic frame_abort;

    modport master (
        output ssel,
        output rd_wr,
        output mosi,
        input  miso,
        input  frame_done,
        input  frame_abort
    );

    modport slave (
        input  ssel,
        input  rd_wr,
        input  mosi,
        output miso,
        output frame_done,
        output frame_abort
    );

endinterface

// File: rtl/spi_regfile.sv
// DEPTH x DATA_W register file: async clear, synchronous write, combinational read.
module spi_regfile
    import spi_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic              waddr_ok_s;
    logic              raddr_ok_s;

    assign waddr_ok_s = addr_in_range(32'(waddr), DEPTH);
    assign raddr_ok_s = addr_in_range(32'(raddr), DEPTH);

    // Storage array: cleared as a whole on reset, writes beyond DEPTH are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (we && waddr_ok_s) begin
            mem_r[waddr[IDX_W-1:0]] <= wdata;
        end
    end

    // Read port: unimplemented addresses read as zero
    always_comb begin
        rdata = '0;
        if (raddr_ok_s) begin
            rdata = mem_r[raddr[IDX_W-1:0]];
        end else begin
            rdata = '0;
        end
    end

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI slave: address then one data word MSB first; writes land in the register
// file, reads stream the stored word back on miso.
module spi_slave_regfile
    import spi_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 256
) (
    input  logic          sclk,
    input  logic          rst_n,
    spi_slave_regfile_if.slave bus
);

    localparam int CNT_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    spi_state_e        state_r,    state_s;
    logic [CNT_W-1:0]  bit_cnt_r,  bit_cnt_s;
    logic [ADDR_W-1:0] addr_r,     addr_s;
    logic [DATA_W-2:0] wr_shift_r, wr_shift_s;
    logic [DATA_W-1:0] rd_shift_r, rd_shift_s;
    logic              rd_wr_r,    rd_wr_s;
    logic              miso_r,     miso_s;
    logic              done_r,     done_s;
    logic              abort_r,    abort_s;

    logic [ADDR_W-1:0] addr_shift_s;
    logic [DATA_W-1:0] wdata_s;
    logic [DATA_W-1:0] rdata_s;
    logic              we_s;

    // The final bit of each field comes straight from mosi on the capturing edge
    assign addr_shift_s = {addr_r[ADDR_W-2:0], bus.mosi};
    assign wdata_s      = {wr_shift_r, bus.mosi};

    spi_regfile #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_regfile (
        .clk   (sclk),
        .rst_n (rst_n),
        .we    (we_s),
        .waddr (addr_r),
        .wdata (wdata_s),
        .raddr (addr_shift_s),
        .rdata (rdata_s)
    );

    // Frame state register, counters, shifters and registered outputs
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            bit_cnt_r  <= '0;
            addr_r     <= '0;
            wr_shift_r <= '0;
            rd_shift_r <= '0;
            rd_wr_r    <= WR;
            miso_r     <= 1'b0;
            done_r     <= 1'b0;
            abort_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            bit_cnt_r  <= bit_cnt_s;
            addr_r     <= addr_s;
            wr_shift_r <= wr_shift_s;
            rd_shift_r <= rd_shift_s;
            rd_wr_r    <= rd_wr_s;
            miso_r     <= miso_s;
            done_r     <= done_s;
            abort_r    <= abort_s;
        end
    end

    // Next-state and output decode; miso and the pulses default low every edge
    always_comb begin
        state_s    = state_r;
        bit_cnt_s  = bit_cnt_r;
        addr_s     = addr_r;
        wr_shift_s = wr_shift_r;
        rd_shift_s = rd_shift_r;
        rd_wr_s    = rd_wr_r;
        miso_s     = 1'b0;
        done_s     = 1'b0;
        abort_s    = 1'b0;
        we_s       = 1'b0;

        case (state_r)
            IDLE: begin
                if (!bus.ssel) begin
                    rd_wr_s   = bus.rd_wr;
                    addr_s    = addr_shift_s;
                    bit_cnt_s = CNT_W'(1);
                    state_s   = ADDR;
                end else begin
                    state_s   = IDLE;
                end
            end

            ADDR: begin
                if (bus.ssel) begin
                    abort_s   = 1'b1;
                    bit_cnt_s = '0;
                    state_s   = IDLE;
                end else begin
                    addr_s    = addr_shift_s;
                    bit_cnt_s = bit_cnt_r + CNT_W'(1);
                    if (bit_cnt_r == CNT_W'(ADDR_W - 1)) begin
                        if (rd_wr_r == RD) begin
                            rd_shift_s = rdata_s;
                            miso_s     = rdata_s[DATA_W-1];
                            bit_cnt_s  = CNT_W'(1);
                            state_s    = RDATA;
                        end else begin
                            bit_cnt_s  = '0;
                            state_s    = WDATA;
                        end
                    end else begin
                        state_s = ADDR;
                    end
                end
            end

            WDATA: begin
                if (bus.ssel) begin
                    abort_s   = 1'b1;
                    bit_cnt_s = '0;
                    state_s   = IDLE;
                end else begin
                    wr_shift_s = wdata_s[DATA_W-2:0];
                    if (bit_cnt_r == CNT_W'(DATA_W - 1)) begin
                        we_s      = 1'b1;
                        done_s    = 1'b1;
                        bit_cnt_s = '0;
                        state_s   = WAIT_DESEL;
                    end else begin
                        bit_cnt_s = bit_cnt_r + CNT_W'(1);
                        state_s   = WDATA;
                    end
                end
            end

            RDATA: begin
                if (bus.ssel) begin
                    abort_s   = 1'b1;
                    bit_cnt_s = '0;
                    state_s   = IDLE;
                end else if (bit_cnt_r == CNT_W'(DATA_W)) begin
                    // LSB has been held for its full cycle
                    done_s    = 1'b1;
                    bit_cnt_s = '0;
                    state_s   = WAIT_DESEL;
                end else begin
                    rd_shift_s = rd_shift_r << 1;
                    miso_s     = rd_shift_r[DATA_W-2];
                    bit_cnt_s  = bit_cnt_r + CNT_W'(1);
                    state_s    = RDATA;
                end
            end

            WAIT_DESEL: begin
                if (bus.ssel) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_DESEL;
                end
            end

            default: begin
                bit_cnt_s = '0;
                state_s   = IDLE;
            end
        endcase
    end

    assign bus.miso        = miso_r;
    assign bus.frame_done  = done_r;
    assign bus.frame_abort = abort_r;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Randomized bench: drives two slaves (DEPTH 256 and 16) with identical frames and
// checks every edge against a frame-level reference model of the register file.
module tb_spi_slave_regfile;

    localparam int AW        = 8;
    localparam int DW        = 8;
    localparam int DEPTH_A   = 256;
    localparam int DEPTH_B   = 16;
    localparam int FRAME_LEN = AW + DW;

    logic sclk = 1'b0;
    logic rst_n;
    logic ssel_d;
    logic rd_wr_d;
    logic mosi_d;

    spi_slave_regfile_if bus_a ();
    spi_slave_regfile_if bus_b ();

    assign bus_a.ssel  = ssel_d;
    assign bus_a.rd_wr = rd_wr_d;
    assign bus_a.mosi  = mosi_d;
    assign bus_b.ssel  = ssel_d;
    assign bus_b.rd_wr = rd_wr_d;
    assign bus_b.mosi  = mosi_d;

    spi_slave_regfile #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH_A)) dut_a (
        .sclk  (sclk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    spi_slave_regfile #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH_B)) dut_b (
        .sclk  (sclk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    always #5 sclk = ~sclk;

    logic [DW-1:0] model_a [DEPTH_A];
    logic [DW-1:0] model_b [DEPTH_B];

    int total_cnt = 0;
    int bad_cnt   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
        total_cnt++;
        if (obs_v !== exp_v) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs_v, exp_v, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH_A; i++) model_a[i] = '0;
        for (int i = 0; i < DEPTH_B; i++) model_b[i] = '0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_miso_a"},  32'(bus_a.miso), 32'd0);
        check_eq({tag, "_miso_b"},  32'(bus_b.miso), 32'd0);
        check_eq({tag, "_done_a"},  32'(bus_a.frame_done), 32'd0);
        check_eq({tag, "_done_b"},  32'(bus_b.frame_done), 32'd0);
        check_eq({tag, "_abort_a"}, 32'(bus_a.frame_abort), 32'd0);
        check_eq({tag, "_abort_b"}, 32'(bus_b.frame_abort), 32'd0);
    endtask

    // One frame: ssel low for nbits edges, then high for gap edges.
    // Edge k (1-based) carries address bits first, then data bits, MSB first.
    // A nonzero rst_edge pulls rst_n low right after that edge has been checked.
    task automatic run_frame(input bit rd, input logic [7:0] addr, input logic [7:0] data,
                             input int nbits, input int gap, input int rst_edge);
        logic [DW-1:0] rdat_a;
        logic [DW-1:0] rdat_b;
        bit            in_data;
        bit            exp_done;
        bit            exp_abort;
        bit            exp_miso_a;
        bit            exp_miso_b;
        rdat_a = model_a[addr];
        rdat_b = (int'(addr) < DEPTH_B) ? model_b[addr[3:0]] : 8'h00;
        for (int k = 1; k <= nbits + gap; k++) begin
            @(negedge sclk);
            ssel_d  = (k <= nbits) ? 1'b0 : 1'b1;
            rd_wr_d = (k == 1) ? rd : 1'($urandom);
            if (k <= AW)             mosi_d = addr[AW-k];
            else if (k <= FRAME_LEN) mosi_d = data[FRAME_LEN-k];
            else                     mosi_d = 1'($urandom);
            @(posedge sclk);
            #1;
            in_data    = rd && (k >= AW) && (k <= FRAME_LEN - 1) && (k <= nbits);
            exp_miso_a = in_data ? rdat_a[FRAME_LEN-1-k] : 1'b0;
            exp_miso_b = in_data ? rdat_b[FRAME_LEN-1-k] : 1'b0;
            exp_done   = (k == FRAME_LEN) && (nbits >= FRAME_LEN);
            exp_abort  = (k == nbits + 1) && (nbits < FRAME_LEN);
            check_eq("miso_a",  32'(bus_a.miso), 32'(exp_miso_a));
            check_eq("miso_b",  32'(bus_b.miso), 32'(exp_miso_b));
            check_eq("done_a",  32'(bus_a.frame_done), 32'(exp_done));
            check_eq("done_b",  32'(bus_b.frame_done), 32'(exp_done));
            check_eq("abort_a", 32'(bus_a.frame_abort), 32'(exp_abort));
            check_eq("abort_b", 32'(bus_b.frame_abort), 32'(exp_abort));
            if (k == rst_edge) begin
                #2;
                rst_n = 1'b0;
                #1;
                check_idle_outputs("midrst");
                clear_model();
                ssel_d = 1'b1;
                @(negedge sclk);
                rst_n = 1'b1;
                return;
            end
        end
        if (!rd && nbits >= FRAME_LEN) begin
            model_a[addr] = data;
            if (int'(addr) < DEPTH_B) model_b[addr[3:0]] = data;
        end
    endtask

    initial begin
        bit          rd;
        logic [7:0]  addr;
        logic [7:0]  data;
        int          sel;
        int          nbits;

        clear_model();
        rst_n   = 1'b0;
        ssel_d  = 1'b1;
        rd_wr_d = 1'b0;
        mosi_d  = 1'b0;
        repeat (3) @(posedge sclk);
        #1;
        check_idle_outputs("reset");
        @(negedge sclk);
        rst_n = 1'b1;
        @(posedge sclk);
        #1;
        check_idle_outputs("post_reset");

        // Read of an untouched location right after reset
        run_frame(1'b1, 8'h33, 8'h00, FRAME_LEN, 1, 0);
        // Write then read back 0xA5
        run_frame(1'b0, 8'h10, 8'hA5, FRAME_LEN, 1, 0);
        run_frame(1'b1, 8'h10, 8'h00, FRAME_LEN, 1, 0);
        // Write aborted after four data bits must not land
        run_frame(1'b0, 8'h20, 8'h3C, AW + 4, 1, 0);
        run_frame(1'b1, 8'h20, 8'h00, FRAME_LEN, 1, 0);
        // Beyond the small instance's depth, and its last valid entry
        run_frame(1'b0, 8'h40, 8'hFF, FRAME_LEN, 1, 0);
        run_frame(1'b1, 8'h40, 8'h00, FRAME_LEN, 1, 0);
        run_frame(1'b0, 8'h0F, 8'h81, FRAME_LEN, 1, 0);
        run_frame(1'b1, 8'h0F, 8'h00, FRAME_LEN, 1, 0);
        // Back-to-back frames with a single deselect edge; ssel held low past the end
        run_frame(1'b0, 8'h01, 8'h11, FRAME_LEN, 1, 0);
        run_frame(1'b0, 8'h02, 8'h22, FRAME_LEN + 6, 1, 0);
        run_frame(1'b1, 8'h01, 8'h00, FRAME_LEN, 1, 0);
        run_frame(1'b1, 8'h02, 8'h00, FRAME_LEN + 4, 2, 0);
        // Aborts in the address phase and in the read data phase
        run_frame(1'b0, 8'h03, 8'h77, 3, 1, 0);
        run_frame(1'b1, 8'h10, 8'h00, AW + 2, 1, 0);

        for (int i = 0; i < 150; i++) begin
            rd    = 1'($urandom);
            addr  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            data  = 8'($urandom);
            sel   = int'($urandom_range(0, 9));
            nbits = (sel < 7) ? FRAME_LEN :
                    (sel < 9) ? int'($urandom_range(1, FRAME_LEN - 1)) :
                                int'($urandom_range(FRAME_LEN + 1, FRAME_LEN + 4));
            run_frame(rd, addr, data, nbits, int'($urandom_range(1, 3)), 0);
        end

        // Reset while the 4th data bit of a read is on miso
        run_frame(1'b0, 8'h05, 8'h5A, FRAME_LEN, 1, 0);
        run_frame(1'b1, 8'h05, 8'h00, FRAME_LEN, 1, AW + 3);
        @(posedge sclk);
        #1;
        check_idle_outputs("after_rst");
        run_frame(1'b1, 8'h05, 8'h00, FRAME_LEN, 1, 0);
        run_frame(1'b1, 8'h10, 8'h00, FRAME_LEN, 1, 0);
        run_frame(1'b1, 8'h0F, 8'h00, FRAME_LEN, 1, 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
